// File: rtl/ps2_ball_ctrl.sv
// ps2_ball_ctrl
// PS/2 keyboard front end plus on-screen ball controller for the VGA demo path.
//
// Ports:
//   CLK       in   system clock
//   reset     in   synchronous, active-high
//   PS2_CLK   in   raw PS/2 clock (asynchronous, synchronised internally)
//   PS2_DATA  in   raw PS/2 data  (asynchronous, synchronised internally)
//   radius    in   ball radius in units; edge clearance = radius*RAD_SCALE
//   ball_x    out  ball centre x
//   ball_y    out  ball centre y
//   color     out  committed colour index
//   key_code  out  last decoded scan code (held)
//   key_valid out  one-cycle pulse per decoded key event
//   key_break out  key_code is a release event
//   key_ext   out  key_code was E0-prefixed
//   frame_err out  one-cycle pulse on start, parity or stop error
module ps2_ball_ctrl #(
  parameter int POS_W          = 11,
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240,
  parameter int STEP           = 5,
  parameter int MARGIN         = 5,
  parameter int RAD_W          = 3,
  parameter int RAD_SCALE      = 5,
  parameter int COLOR_W        = 2,
  parameter int COLOR_INIT     = 1,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               PS2_CLK,
  input  logic               PS2_DATA,
  input  logic [RAD_W-1:0]   radius,
  output logic [POS_W-1:0]   ball_x,
  output logic [POS_W-1:0]   ball_y,
  output logic [COLOR_W-1:0] color,
  output logic [7:0]         key_code,
  output logic               key_valid,
  output logic               key_break,
  output logic               key_ext,
  output logic               frame_err
);

  localparam int SW    = POS_W + 2;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic signed [SW-1:0] STEP_S   = SW'(STEP);
  localparam logic signed [SW-1:0] MARGIN_S = SW'(MARGIN);
  localparam logic signed [SW-1:0] XMAX_S   = SW'(SCREEN_W - 1 - MARGIN);
  localparam logic signed [SW-1:0] YMAX_S   = SW'(SCREEN_H - 1 - MARGIN);

  // ---------------------------------------------------------------------------
  // Input synchronisers and falling-edge detect
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       clk_prev_q;
  logic       fall;
  logic       bit_in;

  always_ff @(posedge CLK) begin
    if (reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DATA};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign fall   = clk_prev_q & ~clk_sync_q[1];
  assign bit_in = dat_sync_q[1];

  // ---------------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  rx_state_t        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             par_q, par_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             good_q, good_d;
  logic             err_q, err_d;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      good_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      good_q  <= good_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    good_d  = 1'b0;
    err_d   = 1'b0;

    // Cycles since the last PS2_CLK falling edge while a frame is open.
    if (state_q == S_IDLE || fall) tmo_d = '0;
    else                           tmo_d = tmo_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          if (!bit_in) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d = {bit_in, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_d   = bit_in;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          if (bit_in && (^{shift_q, par_q})) good_d = 1'b1;
          else                               err_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled partial frame is dropped silently.
    if (state_q != S_IDLE && !fall && tmo_q == TMO_LAST) state_d = S_IDLE;
  end

  assign frame_err = err_q;

  // ---------------------------------------------------------------------------
  // Decoder, ball position and colour
  // ---------------------------------------------------------------------------
  logic               ext_pend_q, ext_pend_d;
  logic               brk_pend_q, brk_pend_d;
  logic [7:0]         code_q, code_d;
  logic               valid_q, valid_d;
  logic               brk_q, brk_d;
  logic               ext_q, ext_d;
  logic [POS_W-1:0]   x_q, x_d;
  logic [POS_W-1:0]   y_q, y_d;
  logic [COLOR_W-1:0] pend_q, pend_d;
  logic [COLOR_W-1:0] color_q, color_d;

  logic signed [SW-1:0] clr, lo, hi_x, hi_y;

  // Move one axis by +/-STEP in widened signed arithmetic, clamped to [lo,hi].
  // An empty range (lo > hi) leaves the position untouched.
  function automatic logic [POS_W-1:0] step_axis(
    input logic [POS_W-1:0]    pos,
    input logic                neg,
    input logic signed [SW-1:0] lo_lim,
    input logic signed [SW-1:0] hi_lim
  );
    logic signed [SW-1:0] p;
    p = $signed({2'b00, pos}) + (neg ? -STEP_S : STEP_S);
    if (lo_lim > hi_lim) return pos;
    if (p < lo_lim) p = lo_lim;
    else if (p > hi_lim) p = hi_lim;
    return p[POS_W-1:0];
  endfunction

  always_comb begin
    clr  = $signed(SW'(radius) * SW'(RAD_SCALE));
    lo   = MARGIN_S + clr;
    hi_x = XMAX_S - clr;
    hi_y = YMAX_S - clr;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      x_q        <= POS_W'(X_INIT);
      y_q        <= POS_W'(Y_INIT);
      pend_q     <= COLOR_W'(COLOR_INIT);
      color_q    <= COLOR_W'(COLOR_INIT);
    end else begin
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pend_q     <= pend_d;
      color_q    <= color_d;
    end
  end

  always_comb begin
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    brk_d      = brk_q;
    ext_d      = ext_q;
    x_d        = x_q;
    y_d        = y_q;
    pend_d     = pend_q;
    color_d    = color_q;

    if (err_q) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (good_q) begin
      if (shift_q == 8'hE0) begin
        ext_pend_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_pend_d = 1'b1;
      end else begin
        valid_d    = 1'b1;
        code_d     = shift_q;
        brk_d      = brk_pend_q;
        ext_d      = ext_pend_q;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
        if (!brk_pend_q) begin
          unique case (shift_q)
            8'h75:   y_d = step_axis(y_q, 1'b1, lo, hi_y);
            8'h72:   y_d = step_axis(y_q, 1'b0, lo, hi_y);
            8'h6B:   x_d = step_axis(x_q, 1'b1, lo, hi_x);
            8'h74:   x_d = step_axis(x_q, 1'b0, lo, hi_x);
            8'h16:   pend_d = COLOR_W'(1);
            8'h1E:   pend_d = COLOR_W'(2);
            8'h26:   pend_d = COLOR_W'(3);
            8'h5A:   color_d = pend_q;
            default: ;
          endcase
        end
      end
    end
  end

  assign ball_x    = x_q;
  assign ball_y    = y_q;
  assign color     = color_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_break = brk_q;
  assign key_ext   = ext_q;

endmodule

// File: tb/tb_ps2_ball_ctrl.sv
// Directed testbench for ps2_ball_ctrl: drives PS/2 frames bit by bit and
// checks decoded events, ball movement/clamping, colour commit and recovery.
module tb_ps2_ball_ctrl;

  localparam int H   = 10;   // CLK cycles per PS/2 clock half-period
  localparam int TMO = 200;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        PS2_CLK = 1'b1;
  logic        PS2_DATA = 1'b1;
  logic [2:0]  radius = '0;
  logic [10:0] ball_x, ball_y;
  logic [1:0]  color;
  logic [7:0]  key_code;
  logic        key_valid, key_break, key_ext, frame_err;

  int vec = 0;
  int miscompares = 0;

  int         ev_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] last_code = '0;
  logic       last_brk = 1'b0;
  logic       last_ext = 1'b0;
  int         max_x = 0;

  ps2_ball_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .reset(reset), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .radius(radius), .ball_x(ball_x), .ball_y(ball_y), .color(color),
    .key_code(key_code), .key_valid(key_valid), .key_break(key_break),
    .key_ext(key_ext), .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  // Event monitor, sampled on the inactive edge.
  always @(negedge CLK) begin
    if (key_valid) begin
      ev_cnt++;
      last_code = key_code;
      last_brk  = key_break;
      last_ext  = key_ext;
    end
    if (frame_err) err_cnt++;
    if (int'(ball_x) > max_x) max_x = int'(ball_x);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DATA = b;
    idle(H);
    PS2_CLK = 1'b0;
    idle(H);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par_ok ? ~^b : ^b);
    ps2_bit(stop);
    PS2_DATA = 1'b1;
    idle(2 * H);
  endtask

  task automatic do_reset;
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    reset    = 1'b1;
    idle(4);
    reset    = 1'b0;
    idle(2);
    max_x    = 0;
  endtask

  task automatic test_reset;
    do_reset();
    vec++; if (ball_x !== 11'd320) begin miscompares++; $display("FAIL rst_x got %0d exp 320", ball_x); end
    vec++; if (ball_y !== 11'd240) begin miscompares++; $display("FAIL rst_y got %0d exp 240", ball_y); end
    vec++; if (color !== 2'd1) begin miscompares++; $display("FAIL rst_color got %0d exp 1", color); end
    vec++; if (key_code !== 8'h00) begin miscompares++; $display("FAIL rst_code got %0h exp 0", key_code); end
    vec++; if ({key_valid, key_break, key_ext, frame_err} !== 4'b0000) begin
      miscompares++; $display("FAIL rst_flags got %b exp 0000", {key_valid, key_break, key_ext, frame_err});
    end
  endtask

  task automatic test_make_right;
    int e0;
    do_reset();
    e0 = ev_cnt;
    send_frame(8'h74, 1'b1, 1'b1);
    vec++; if (ev_cnt - e0 !== 1) begin miscompares++; $display("FAIL right_events got %0d exp 1", ev_cnt - e0); end
    vec++; if ({last_code, last_brk, last_ext} !== {8'h74, 2'b00}) begin
      miscompares++; $display("FAIL right_event got %0h/%b/%b exp 74/0/0", last_code, last_brk, last_ext);
    end
    vec++; if (ball_x !== 11'd325) begin miscompares++; $display("FAIL right_x got %0d exp 325", ball_x); end
    vec++; if (ball_y !== 11'd240) begin miscompares++; $display("FAIL right_y got %0d exp 240", ball_y); end
  endtask

  task automatic test_break_ext;
    int e0;
    do_reset();
    e0 = ev_cnt;
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h74, 1'b1, 1'b1);
    vec++; if (ev_cnt - e0 !== 1) begin miscompares++; $display("FAIL brk_events got %0d exp 1", ev_cnt - e0); end
    vec++; if ({last_code, last_brk, last_ext} !== {8'h74, 2'b10}) begin
      miscompares++; $display("FAIL brk_event got %0h/%b/%b exp 74/1/0", last_code, last_brk, last_ext);
    end
    vec++; if (ball_x !== 11'd320) begin miscompares++; $display("FAIL brk_x got %0d exp 320", ball_x); end
    send_frame(8'hE0, 1'b1, 1'b1);
    send_frame(8'h75, 1'b1, 1'b1);
    vec++; if (ev_cnt - e0 !== 2) begin miscompares++; $display("FAIL ext_events got %0d exp 2", ev_cnt - e0); end
    vec++; if ({last_code, last_brk, last_ext} !== {8'h75, 2'b01}) begin
      miscompares++; $display("FAIL ext_event got %0h/%b/%b exp 75/0/1", last_code, last_brk, last_ext);
    end
    vec++; if (ball_y !== 11'd235) begin miscompares++; $display("FAIL ext_y got %0d exp 235", ball_y); end
  endtask

  task automatic test_parity_err;
    int e0, r0;
    do_reset();
    e0 = ev_cnt; r0 = err_cnt;
    send_frame(8'h74, 1'b0, 1'b1);
    vec++; if (err_cnt - r0 !== 1) begin miscompares++; $display("FAIL par_err got %0d exp 1", err_cnt - r0); end
    vec++; if (ev_cnt - e0 !== 0) begin miscompares++; $display("FAIL par_events got %0d exp 0", ev_cnt - e0); end
    vec++; if (ball_x !== 11'd320) begin miscompares++; $display("FAIL par_x got %0d exp 320", ball_x); end
    send_frame(8'h6B, 1'b1, 1'b1);
    vec++; if (ball_x !== 11'd315) begin miscompares++; $display("FAIL left_x got %0d exp 315", ball_x); end
    send_frame(8'h6B, 1'b1, 1'b0);
    vec++; if (err_cnt - r0 !== 2) begin miscompares++; $display("FAIL stop_err got %0d exp 2", err_cnt - r0); end
    vec++; if (ball_x !== 11'd315) begin miscompares++; $display("FAIL stop_x got %0d exp 315", ball_x); end
  endtask

  task automatic test_timeout;
    int e0, r0;
    do_reset();
    e0 = ev_cnt; r0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    PS2_DATA = 1'b1;
    idle(TMO + 20);
    send_frame(8'h72, 1'b1, 1'b1);
    vec++; if (err_cnt - r0 !== 0) begin miscompares++; $display("FAIL tmo_err got %0d exp 0", err_cnt - r0); end
    vec++; if (ev_cnt - e0 !== 1) begin miscompares++; $display("FAIL tmo_events got %0d exp 1", ev_cnt - e0); end
    vec++; if (last_code !== 8'h72) begin miscompares++; $display("FAIL tmo_code got %0h exp 72", last_code); end
    vec++; if (ball_y !== 11'd245) begin miscompares++; $display("FAIL tmo_y got %0d exp 245", ball_y); end
  endtask

  task automatic test_clamp;
    do_reset();
    radius = 3'd3;
    for (int i = 0; i < 60; i++) send_frame(8'h74, 1'b1, 1'b1);
    vec++; if (ball_x !== 11'd619) begin miscompares++; $display("FAIL clamp_x got %0d exp 619", ball_x); end
    vec++; if (max_x > 619) begin miscompares++; $display("FAIL clamp_max got %0d exp <=619", max_x); end
    radius = 3'd7;   // bounds now [40, 599] / [40, 439]
    send_frame(8'h75, 1'b1, 1'b1);
    vec++; if (ball_x !== 11'd619) begin miscompares++; $display("FAIL axis_x got %0d exp 619", ball_x); end
    vec++; if (ball_y !== 11'd235) begin miscompares++; $display("FAIL axis_y got %0d exp 235", ball_y); end
    send_frame(8'h6B, 1'b1, 1'b1);
    vec++; if (ball_x !== 11'd599) begin miscompares++; $display("FAIL reclamp_x got %0d exp 599", ball_x); end
    radius = 3'd0;
  endtask

  task automatic test_color_reset;
    int e0, r0;
    do_reset();
    send_frame(8'h1E, 1'b1, 1'b1);
    vec++; if (color !== 2'd1) begin miscompares++; $display("FAIL pend_color got %0d exp 1", color); end
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h5A, 1'b1, 1'b1);
    vec++; if (color !== 2'd1) begin miscompares++; $display("FAIL brk_enter got %0d exp 1", color); end
    send_frame(8'h5A, 1'b1, 1'b1);
    vec++; if (color !== 2'd2) begin miscompares++; $display("FAIL commit_color got %0d exp 2", color); end
    send_frame(8'h74, 1'b1, 1'b1);
    e0 = ev_cnt; r0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    do_reset();
    idle(3 * H);
    vec++; if (color !== 2'd1) begin miscompares++; $display("FAIL mid_color got %0d exp 1", color); end
    vec++; if ({ball_x, ball_y} !== {11'd320, 11'd240}) begin
      miscompares++; $display("FAIL mid_pos got %0d,%0d exp 320,240", ball_x, ball_y);
    end
    vec++; if (ev_cnt - e0 !== 0 || err_cnt - r0 !== 0) begin
      miscompares++; $display("FAIL mid_events got ev %0d err %0d exp 0 0", ev_cnt - e0, err_cnt - r0);
    end
  endtask

  initial begin
    test_reset();
    test_make_right();
    test_break_ext();
    test_parity_err();
    test_timeout();
    test_clamp();
    test_color_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
    $finish;
  end

endmodule
